// File: rtl/eightbit_pipe_subtractor.sv
// eightbit_pipe_subtractor: pipelined {bout,diff}=a-b-b_in, borrow chain over STAGES slices, valid/ready both sides; PIPE_SUB_SAT_EN clamps diff to 0 on borrow
module eightbit_pipe_subtractor #(
  parameter int WIDTH = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             b_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);
  localparam int S = WIDTH / STAGES;
  logic adv;
  logic [WIDTH-1:0] res;
  assign adv = !out_valid || out_ready;
  assign in_ready = adv;
  for (genvar k = 0; k < STAGES; k++) begin : st
    logic [WIDTH-k*S-1:0] ai, bi;
    logic [k*S:0] di;
    logic vi;
    logic [S:0] r;
    logic [(k+1)*S:0] dn;
    always_comb begin
      r = {1'b0, ai[S-1:0]} - {1'b0, bi[S-1:0]} - (S+1)'(di[0]);
      dn = {r[S-1:0], di};
      dn[0] = r[S];
    end
    if (k == 0) begin : src
      assign ai = a;
      assign bi = b;
      assign di = b_in;
      assign vi = in_valid;
    end else begin : pipe
      always_ff @(posedge clk) begin
        if (rst) vi <= 1'b0;
        else if (adv) vi <= st[k-1].vi;
        if (adv) begin
          ai <= st[k-1].ai[WIDTH-(k-1)*S-1:S];
          bi <= st[k-1].bi[WIDTH-(k-1)*S-1:S];
          di <= st[k-1].dn;
        end
      end
    end
  end
`ifdef PIPE_SUB_SAT_EN
  assign res = st[STAGES-1].dn[0] ? '0 : st[STAGES-1].dn[WIDTH:1];
`else
  assign res = st[STAGES-1].dn[WIDTH:1];
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      diff <= '0;
      bout <= 1'b0;
    end else if (adv) begin
      out_valid <= st[STAGES-1].vi;
      if (st[STAGES-1].vi) begin
        diff <= res;
        bout <= st[STAGES-1].dn[0];
      end
    end
  end
endmodule
